// File: rtl/param_memory_ctrl.sv
// Parametrised single-port working memory: registered 1-cycle reads, write-first
// collisions, post-reset init sweep with busy flag, and a sticky range-error flag.
module param_memory_ctrl #(
   parameter int unsigned        DATA_W     = 16,
   parameter int unsigned        ADDR_W     = 8,
   parameter int unsigned        DEPTH      = 256,
   parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              readMem,
   input  logic              writeMem,
   input  logic [ADDR_W-1:0] addrBus,
   input  logic [DATA_W-1:0] inBus,
   output logic [DATA_W-1:0] outBus,
   output logic              rdValid,
   output logic              busy,
   output logic              errFlag
);

   // One extra counter bit so DEPTH == 2**ADDR_W still has a representable end.
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic {INIT, READY} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               in_range_c;
   logic               mem_we_c;
   logic [ADDR_W-1:0]  mem_addr_c;
   logic [DATA_W-1:0]  mem_data_c;

   assign in_range_c = {1'b0, addrBus} < CNT_W'(DEPTH);

   // Single write port shared by the init sweep and user writes.
   always_comb begin
      mem_we_c   = 1'b0;
      mem_addr_c = addrBus;
      mem_data_c = inBus;
      if (state == INIT) begin
         mem_we_c   = 1'b1;
         mem_addr_c = cnt[ADDR_W-1:0];
         mem_data_c = INIT_VALUE;
      end else if (writeMem && in_range_c) begin
         mem_we_c = 1'b1;
      end
   end

   // Array has no reset: contents survive rst until the sweep overwrites them.
   always_ff @(posedge clk) begin
      if (mem_we_c) mem[mem_addr_c] <= mem_data_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= INIT;
         cnt     <= '0;
         busy    <= 1'b1;
         outBus  <= '0;
         rdValid <= 1'b0;
         errFlag <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               rdValid <= 1'b0;
               cnt     <= CNT_W'(cnt + 1'b1);
               if (cnt == CNT_W'(DEPTH - 1)) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               rdValid <= readMem;
               if (readMem) begin
                  if (!in_range_c)   outBus <= '0;
                  else if (writeMem) outBus <= inBus;
                  else               outBus <= mem[addrBus];
               end
               if ((readMem || writeMem) && !in_range_c) errFlag <= 1'b1;
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_param_memory_ctrl.sv
// Bench for param_memory_ctrl: two instances (full depth and partial depth) driven
// by the same stimulus, each checked every cycle against a behavioural model.
module tb_param_memory_ctrl;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          readMem = 1'b0;
   logic          writeMem = 1'b0;
   logic [AW-1:0] addrBus = '0;
   logic [DW-1:0] inBus = '0;

   logic [DW-1:0] out0, out1;
   logic          vld0, vld1, busy0, busy1, err0, err1;

   always #5 clk = ~clk;

   param_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .INIT_VALUE(16'h0000)) u0 (
      .clk(clk), .rst(rst), .readMem(readMem), .writeMem(writeMem), .addrBus(addrBus),
      .inBus(inBus), .outBus(out0), .rdValid(vld0), .busy(busy0), .errFlag(err0));

   param_memory_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(200), .INIT_VALUE(16'h5A5A)) u1 (
      .clk(clk), .rst(rst), .readMem(readMem), .writeMem(writeMem), .addrBus(addrBus),
      .inBus(inBus), .outBus(out1), .rdValid(vld1), .busy(busy1), .errFlag(err1));

   int errors = 0;
   int checks = 0;

   // Reference model state, one slot per instance.
   int            depth [2] = '{256, 200};
   logic [DW-1:0] initv [2] = '{16'h0000, 16'h5A5A};
   logic [DW-1:0] mm    [2][256];
   int            bl    [2];
   logic [DW-1:0] eo    [2];
   logic          ev    [2];
   logic          ee    [2];

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 2; k++) begin
         logic [DW-1:0] o;
         logic v, b, e;
         o = (k == 0) ? out0  : out1;
         v = (k == 0) ? vld0  : vld1;
         b = (k == 0) ? busy0 : busy1;
         e = (k == 0) ? err0  : err1;
         chk($sformatf("busy%0d@%0t", k, $time),    DW'(b), DW'(bl[k] > 0));
         chk($sformatf("rdValid%0d@%0t", k, $time), DW'(v), DW'(ev[k]));
         chk($sformatf("errFlag%0d@%0t", k, $time), DW'(e), DW'(ee[k]));
         chk($sformatf("outBus%0d@%0t", k, $time),  o,      eo[k]);
      end
   endtask

   // One clock: drive request, advance model by the spec rules, then compare.
   task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
      readMem = r; writeMem = w; addrBus = a; inBus = d;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         if (bl[k] > 0) begin
            mm[k][depth[k] - bl[k]] = initv[k];
            bl[k]--;
            ev[k] = 1'b0;
         end else begin
            logic inr;
            inr = int'(a) < depth[k];
            if (w && inr) mm[k][a] = d;
            if (r) eo[k] = inr ? mm[k][a] : '0;
            ev[k] = r;
            if ((r || w) && !inr) ee[k] = 1'b1;
         end
      end
      #1;
      check_all();
   endtask

   task automatic do_reset();
      readMem = 1'b0; writeMem = 1'b0;
      rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         bl[k] = depth[k];
         eo[k] = '0;
         ev[k] = 1'b0;
         ee[k] = 1'b0;
      end
      check_all();
      #1 rst = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 256; i++) mm[k][i] = '0;

      #2;
      do_reset();
      // Requests while busy must be ignored.
      idle(10);
      step(1'b1, 1'b1, 8'd3, 16'hFFFF);
      step(1'b0, 1'b1, 8'd3, 16'hFFFF);
      step(1'b1, 1'b0, 8'd220, 16'h0);
      idle(256 - 13 + 2);

      // Out-of-range write/read (error only on the 200-deep instance).
      step(1'b0, 1'b1, 8'd10,  16'h1111);
      step(1'b0, 1'b1, 8'd210, 16'hAAAA);
      step(1'b1, 1'b0, 8'd210, 16'h0);
      step(1'b1, 1'b0, 8'd10,  16'h0);
      step(1'b1, 1'b0, 8'd3,   16'h0);
      idle(2);

      // Init contents at the boundary addresses.
      step(1'b1, 1'b0, 8'd0,   16'h0);
      step(1'b1, 1'b0, 8'd128, 16'h0);
      step(1'b1, 1'b0, 8'd255, 16'h0);
      idle(1);

      // Write then read, then back-to-back reads.
      step(1'b0, 1'b1, 8'h05, 16'hBEEF);
      step(1'b1, 1'b0, 8'h05, 16'h0);
      idle(1);
      step(1'b1, 1'b0, 8'h05, 16'h0);
      step(1'b1, 1'b0, 8'h00, 16'h0);
      step(1'b1, 1'b0, 8'h05, 16'h0);
      idle(2);

      // Write-first collision.
      step(1'b1, 1'b1, 8'h10, 16'h1234);
      idle(1);
      step(1'b1, 1'b0, 8'h10, 16'h0);
      idle(1);

      // Random traffic over the whole address range.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom_range(0, 255)), DW'($urandom));
      idle(1);

      // Reset mid-sweep: contents reinitialised, full sweep after second release.
      step(1'b0, 1'b1, 8'd7, 16'hC0DE);
      step(1'b1, 1'b0, 8'd7, 16'h0);
      do_reset();
      idle(50);
      do_reset();
      idle(256);
      step(1'b1, 1'b0, 8'd7, 16'h0);
      step(1'b1, 1'b0, 8'd3, 16'h0);
      step(1'b1, 1'b0, 8'h05, 16'h0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/param_memory_ctrl.md
Name: param_memory_ctrl

Overview:
- Parametrised successor to the team's single-port data memory; the sort datapath and the testbench models use it as working storage.
- Adds configurable width and depth, a synchronous registered read with a valid strobe, and write-first collision handling.
- Adds a hardware initialisation sweep after reset with a busy flag, plus sticky range-error detection.
- No file I/O; contents are defined entirely by the reset sweep and by writes.

Parameters:
DATA_W, 16, word width in bits
ADDR_W, 8, address width in bits
DEPTH, 256, number of implemented words; must satisfy 1 <= DEPTH <= 2**ADDR_W
INIT_VALUE, 0, DATA_W-bit value written to every word by the init sweep

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
readMem  input  1  read request, sampled at posedge clk
writeMem  input  1  write request, sampled at posedge clk
addrBus  input  ADDR_W  address for both read and write in the same cycle
inBus  input  DATA_W  write data
outBus  output  DATA_W  registered read data; holds its value between reads
rdValid  output  1  one-cycle pulse: outBus updated by the read accepted in the previous cycle
busy  output  1  high while the init sweep runs; requests are ignored
errFlag  output  1  sticky flag: an accepted request used addrBus >= DEPTH

Behaviour:
- Asynchronous reset (rst=1, immediate, no clock needed):
  - FSM goes to INIT and the sweep counter clears to 0.
  - busy=1, outBus=0, rdValid=0, errFlag=0.
  - Array contents are not touched during reset.
- FSM states:
  - INIT: each cycle writes INIT_VALUE to mem[cnt] and increments cnt. When cnt==DEPTH-1 is written, next state is READY, with busy=0 from that next cycle. The sweep lasts exactly DEPTH cycles after rst deasserts.
  - READY: services requests. There is no return to INIT except via rst.
- Reset mid-sweep or mid-operation: the sweep restarts from address 0 and any in-flight read is dropped (rdValid stays 0).
- In INIT, readMem and writeMem are ignored: no write, no rdValid, no errFlag update.
- Write (READY, writeMem=1, addrBus<DEPTH): mem[addrBus] <= inBus at the edge.
- Read (READY, readMem=1, addrBus<DEPTH): at the edge, outBus <= mem[addrBus] and rdValid=1 for exactly that following cycle. Latency is 1 clock.
- Back-to-back reads: one result per cycle, with rdValid held high continuously.
- readMem and writeMem together (same address by definition): write-first. The write is performed, outBus <= inBus, and rdValid=1.
- Out of range (addrBus>=DEPTH, READY, either request):
  - The write is discarded.
  - A read drives outBus <= 0 with rdValid=1.
  - errFlag sets and stays set until rst.
- No request: outBus holds its value and rdValid=0.
- Width rules: no arithmetic on data. cnt is ADDR_W+1 bits wide so DEPTH=2**ADDR_W terminates correctly.
- outBus is never tri-stated.

Test Plan:
- Reset/init: pulse rst with DATA_W=16, DEPTH=256, INIT_VALUE=16'h0000.
  - busy=1 for exactly 256 cycles after rst falls, then 0.
  - Reads of addresses 0, 128 and 255 return 16'h0000 with rdValid one cycle later.
- Write/read, then back-to-back: write 16'hBEEF to address 8'h05, then read 8'h05.
  - The next cycle gives outBus=16'hBEEF and rdValid=1.
  - Three consecutive reads of 5, 0 and 5 give 16'hBEEF, 16'h0000, 16'hBEEF on consecutive cycles, with rdValid high for 3 cycles.
- Collision: readMem=writeMem=1, addr 8'h10, inBus=16'h1234 -> the next cycle gives outBus=16'h1234, and a later read of 8'h10 also returns 16'h1234.
- Out of range: DEPTH=200, write 16'hAAAA to address 8'd210 and then read 8'd210.
  - The read returns outBus=0 with rdValid=1.
  - errFlag=1 and stays set.
  - A read of address 8'd10 still returns its prior value.
- Reset mid-sweep: assert rst at sweep cycle 50 (DEPTH=256).
  - busy stays 1 for a full 256 cycles after the second deassertion.
  - A word written before the reset reads back INIT_VALUE after the sweep.
- Requests during INIT: write 16'hFFFF to address 3 while busy=1.
  - No rdValid and no errFlag.
  - After the sweep, address 3 reads INIT_VALUE.
